// File: rtl/rob_nway_pkg.sv
// Shared types and defaults for the N-wide reorder buffer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package rob_nway_pkg;

    localparam int ROB_DEF_ENTRIES        = 32;
    localparam int ROB_DEF_DISPATCH_WIDTH = 2;
    localparam int ROB_DEF_COMMIT_WIDTH   = 2;
    localparam int ROB_DEF_CDB_PORTS      = 2;
    localparam int ROB_DEF_ARCH_REG_WIDTH = 5;

    // Per-entry status flags. The destination register index lives in a
    // separate array so its width can follow the module parameter.
    typedef struct packed {
        logic valid;
        logic done;
        logic exc;
        logic has_rd;
        logic is_store;
    } rob_entry_t;

    function automatic int rob_tag_width(input int entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/rob_nway_if.sv
// Dispatch / writeback / retire bus between the pipeline and the ROB.
// Latency: n/a (wires only); master = pipeline side, slave = ROB side.
// Backpressure: alloc_rdy gates a whole dispatch group; retire and CDB have none.
interface rob_nway_if
    import rob_nway_pkg::*;
#(
    parameter int DISPATCH_WIDTH = ROB_DEF_DISPATCH_WIDTH,
    parameter int COMMIT_WIDTH   = ROB_DEF_COMMIT_WIDTH,
    parameter int CDB_PORTS      = ROB_DEF_CDB_PORTS,
    parameter int TAG_WIDTH      = rob_tag_width(ROB_DEF_ENTRIES),
    parameter int ARCH_REG_WIDTH = ROB_DEF_ARCH_REG_WIDTH
);
    // dispatch
    logic [DISPATCH_WIDTH-1:0]                alloc_val;
    logic [DISPATCH_WIDTH*ARCH_REG_WIDTH-1:0] alloc_rd;
    logic [DISPATCH_WIDTH-1:0]                alloc_has_rd;
    logic [DISPATCH_WIDTH-1:0]                alloc_is_store;
    logic                                     alloc_rdy;
    logic [DISPATCH_WIDTH*TAG_WIDTH-1:0]      alloc_tag;
    // writeback
    logic [CDB_PORTS-1:0]                     cdb_val;
    logic [CDB_PORTS*TAG_WIDTH-1:0]           cdb_tag;
    logic [CDB_PORTS-1:0]                     cdb_exc;
    // retire
    logic [COMMIT_WIDTH-1:0]                  commit_val;
    logic [COMMIT_WIDTH*TAG_WIDTH-1:0]        commit_tag;
    logic [COMMIT_WIDTH*ARCH_REG_WIDTH-1:0]   commit_rd;
    logic [COMMIT_WIDTH-1:0]                  commit_has_rd;
    logic                                     store_val;
    logic [TAG_WIDTH-1:0]                     store_id;
    logic                                     exc_val;
    logic [TAG_WIDTH-1:0]                     exc_tag;

    modport master (
        output alloc_val, alloc_rd, alloc_has_rd, alloc_is_store,
        output cdb_val, cdb_tag, cdb_exc,
        input  alloc_rdy, alloc_tag,
        input  commit_val, commit_tag, commit_rd, commit_has_rd,
        input  store_val, store_id, exc_val, exc_tag
    );

    modport slave (
        input  alloc_val, alloc_rd, alloc_has_rd, alloc_is_store,
        input  cdb_val, cdb_tag, cdb_exc,
        output alloc_rdy, alloc_tag,
        output commit_val, commit_tag, commit_rd, commit_has_rd,
        output store_val, store_id, exc_val, exc_tag
    );

endinterface

// File: rtl/rob_nway_commit_select.sv
// Retire-window scan from head: in-order commit mask, one-store cut, exception cut.
// Latency: purely combinational; the caller applies the result at the next edge.
// Backpressure: cache_stall or flush empties the mask; an excepting head blocks all.
// Ports: win[k] = entry at head+k; commit_mask/store_oh/commit_has_rd per lane; exc_head.
module rob_nway_commit_select
    import rob_nway_pkg::*;
#(
    parameter int COMMIT_WIDTH = ROB_DEF_COMMIT_WIDTH
) (
    input  rob_entry_t              win [COMMIT_WIDTH],
    input  logic                    cache_stall,
    input  logic                    flush,
    output logic [COMMIT_WIDTH-1:0] commit_mask,
    output logic [COMMIT_WIDTH-1:0] store_oh,
    output logic [COMMIT_WIDTH-1:0] commit_has_rd,
    output logic                    exc_head
);

    logic run;
    logic store_seen;

    always_comb begin
        commit_mask   = '0;
        store_oh      = '0;
        commit_has_rd = '0;
        run           = !cache_stall && !flush;
        store_seen    = 1'b0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            // The first lane that cannot go (not done, excepting, or a second
            // store) ends the group; nothing younger may pass it.
            if (run && win[k].valid && win[k].done && !win[k].exc &&
                !(win[k].is_store && store_seen)) begin
                commit_mask[k]   = 1'b1;
                commit_has_rd[k] = win[k].has_rd;
                if (win[k].is_store) begin
                    store_oh[k] = 1'b1;
                    store_seen  = 1'b1;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

    assign exc_head = win[0].valid && win[0].done && win[0].exc;

endmodule

// File: rtl/rob_nway.sv
// N-wide reorder buffer: group allocate, CDB completion, in-order retire.
// Latency: alloc/CDB visible to retire the cycle after the edge; retire is same-cycle combinational.
// Backpressure: alloc_rdy=0 unless a full dispatch group fits; lanes offered while low are dropped.
// Ports: clk, rst (async active-low), flush, cache_stall, rif (slave bus), rob_head/rob_tail/rob_count.
module rob_nway
    import rob_nway_pkg::*;
#(
    parameter int ENTRIES        = ROB_DEF_ENTRIES,
    parameter int DISPATCH_WIDTH = ROB_DEF_DISPATCH_WIDTH,
    parameter int COMMIT_WIDTH   = ROB_DEF_COMMIT_WIDTH,
    parameter int CDB_PORTS      = ROB_DEF_CDB_PORTS,
    parameter int TAG_WIDTH      = rob_tag_width(ENTRIES),
    parameter int ARCH_REG_WIDTH = ROB_DEF_ARCH_REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 cache_stall,
    rob_nway_if.slave            rif,
    output logic [TAG_WIDTH-1:0] rob_head,
    output logic [TAG_WIDTH-1:0] rob_tail,
    output logic [TAG_WIDTH:0]   rob_count
);

    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [TAG_WIDTH:0]   ptr_t;   // MSB is the wrap bit

    rob_entry_t                ent  [ENTRIES];
    logic [ARCH_REG_WIDTH-1:0] rd_q [ENTRIES];

    ptr_t head;
    ptr_t tail;
    ptr_t count;
    ptr_t free_slots;
    ptr_t alloc_n;
    ptr_t commit_n;
    logic alloc_rdy;

    tag_t       alloc_idx [DISPATCH_WIDTH];
    tag_t       cdb_idx   [CDB_PORTS];
    tag_t       win_idx   [COMMIT_WIDTH];
    rob_entry_t win       [COMMIT_WIDTH];

    logic [COMMIT_WIDTH-1:0]   commit_mask;
    logic [COMMIT_WIDTH-1:0]   store_oh;
    logic [COMMIT_WIDTH-1:0]   commit_has_rd;
    logic                      exc_head;
    logic [DISPATCH_WIDTH-1:0] alloc_val_inc;

    // Occupancy and readiness come from registered pointers only, so slots
    // freed by this cycle's retirement are not offered to dispatch yet.
    assign count      = tail - head;
    assign free_slots = ptr_t'(ENTRIES) - count;
    assign alloc_rdy  = free_slots >= ptr_t'(DISPATCH_WIDTH);

    assign rob_head  = head[TAG_WIDTH-1:0];
    assign rob_tail  = tail[TAG_WIDTH-1:0];
    assign rob_count = count;

    always_comb begin
        rif.alloc_tag = '0;
        alloc_n       = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            alloc_idx[i] = tail[TAG_WIDTH-1:0] + tag_t'(i);
            rif.alloc_tag[i*TAG_WIDTH +: TAG_WIDTH] = alloc_idx[i];
            if (rif.alloc_val[i]) begin
                alloc_n = alloc_n + ptr_t'(1);
            end
        end
    end
    assign rif.alloc_rdy = alloc_rdy;

    always_comb begin
        for (int p = 0; p < CDB_PORTS; p++) begin
            cdb_idx[p] = rif.cdb_tag[p*TAG_WIDTH +: TAG_WIDTH];
        end
    end

    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            win_idx[k] = head[TAG_WIDTH-1:0] + tag_t'(k);
            win[k]     = ent[win_idx[k]];
        end
    end

    rob_nway_commit_select #(
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_sel (
        .win           (win),
        .cache_stall   (cache_stall),
        .flush         (flush),
        .commit_mask   (commit_mask),
        .store_oh      (store_oh),
        .commit_has_rd (commit_has_rd),
        .exc_head      (exc_head)
    );

    // Retire outputs are zeroed on idle lanes so downstream never sees stale tags.
    always_comb begin
        rif.commit_val    = commit_mask;
        rif.commit_has_rd = commit_has_rd;
        rif.commit_tag    = '0;
        rif.commit_rd     = '0;
        rif.store_id      = '0;
        commit_n          = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_mask[k]) begin
                rif.commit_tag[k*TAG_WIDTH +: TAG_WIDTH]     = win_idx[k];
                rif.commit_rd[k*ARCH_REG_WIDTH +: ARCH_REG_WIDTH] = rd_q[win_idx[k]];
                commit_n = commit_n + ptr_t'(1);
            end
            if (store_oh[k]) begin
                rif.store_id = win_idx[k];
            end
        end
    end
    assign rif.store_val = |store_oh;
    assign rif.exc_val   = exc_head;
    assign rif.exc_tag   = exc_head ? head[TAG_WIDTH-1:0] : '0;

    // Update order matters: CDB first, then retirement clears, then allocation.
    // A CDB write to a retiring entry is overridden by the clear; allocation
    // only targets slots that are already free, so it never collides.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                ent[e]  <= '0;
                rd_q[e] <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                ent[e] <= '0;
            end
        end else begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (rif.cdb_val[p] && ent[cdb_idx[p]].valid) begin
                    ent[cdb_idx[p]].done <= 1'b1;
                    // Only ever set, so duplicate tags across ports OR together.
                    if (rif.cdb_exc[p]) begin
                        ent[cdb_idx[p]].exc <= 1'b1;
                    end
                end
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (commit_mask[k]) begin
                    ent[win_idx[k]] <= '0;
                end
            end
            if (alloc_rdy) begin
                for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                    if (rif.alloc_val[i]) begin
                        ent[alloc_idx[i]] <= '{valid:    1'b1,
                                               done:     1'b0,
                                               exc:      1'b0,
                                               has_rd:   rif.alloc_has_rd[i],
                                               is_store: rif.alloc_is_store[i]};
                        rd_q[alloc_idx[i]] <= rif.alloc_rd[i*ARCH_REG_WIDTH +: ARCH_REG_WIDTH];
                    end
                end
            end
            head <= head + commit_n;
            tail <= tail + (alloc_rdy ? alloc_n : ptr_t'(0));
        end
    end

    // Dispatch lanes must be filled from lane 0 upward: value is 2^k-1.
    assign alloc_val_inc = rif.alloc_val + DISPATCH_WIDTH'(1);
    a_alloc_contig: assert property (@(posedge clk) disable iff (!rst)
        ((rif.alloc_val & alloc_val_inc) == '0));

endmodule

// File: tb/tb_rob_nway.sv
// Randomised + directed bench for rob_nway with an in-order queue reference model.
// Latency: one expectation record per cycle, checked on the falling edge.
// Backpressure: model mirrors group-level alloc_rdy from occupancy.
module tb_rob_nway;

    localparam int N  = 32;
    localparam int DW = 2;
    localparam int CW = 2;
    localparam int CP = 2;
    localparam int TW = 5;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          cache_stall = 1'b0;
    logic [TW-1:0] rob_head;
    logic [TW-1:0] rob_tail;
    logic [TW:0]   rob_count;

    rob_nway_if #(.DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW), .CDB_PORTS(CP),
                  .TAG_WIDTH(TW), .ARCH_REG_WIDTH(AW)) rif ();

    rob_nway #(.ENTRIES(N), .DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW), .CDB_PORTS(CP),
               .TAG_WIDTH(TW), .ARCH_REG_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .cache_stall (cache_stall),
        .rif         (rif),
        .rob_head    (rob_head),
        .rob_tail    (rob_tail),
        .rob_count   (rob_count)
    );

    always #5 clk = ~clk;

    // Reference: program-order list of in-flight ops; head index kept mod N.
    typedef struct {
        int         tag;
        logic [AW-1:0] rd;
        logic       has_rd;
        logic       is_store;
        logic       done;
        logic       exc;
    } op_t;

    typedef struct packed {
        logic            rdy;
        logic [DW*TW-1:0] atag;
        logic [CW-1:0]   cval;
        logic [CW*TW-1:0] ctag;
        logic [CW*AW-1:0] crd;
        logic [CW-1:0]   chas;
        logic            sval;
        logic [TW-1:0]   sid;
        logic            xval;
        logic [TW-1:0]   xtag;
        logic [TW-1:0]   head;
        logic [TW-1:0]   tail;
        logic [TW:0]     cnt;
    } exp_t;

    op_t  mq[$];
    int   mhead = 0;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares all outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("alloc_rdy",     64'(rif.alloc_rdy),     64'(e.rdy));
                chk("alloc_tag",     64'(rif.alloc_tag),     64'(e.atag));
                chk("commit_val",    64'(rif.commit_val),    64'(e.cval));
                chk("commit_tag",    64'(rif.commit_tag),    64'(e.ctag));
                chk("commit_rd",     64'(rif.commit_rd),     64'(e.crd));
                chk("commit_has_rd", 64'(rif.commit_has_rd), 64'(e.chas));
                chk("store_val",     64'(rif.store_val),     64'(e.sval));
                chk("store_id",      64'(rif.store_id),      64'(e.sid));
                chk("exc_val",       64'(rif.exc_val),       64'(e.xval));
                chk("exc_tag",       64'(rif.exc_tag),       64'(e.xtag));
                chk("rob_head",      64'(rob_head),          64'(e.head));
                chk("rob_tail",      64'(rob_tail),          64'(e.tail));
                chk("rob_count",     64'(rob_count),         64'(e.cnt));
            end
        end
    end

    task automatic idle();
        rif.alloc_val      = '0;
        rif.alloc_rd       = '0;
        rif.alloc_has_rd   = '0;
        rif.alloc_is_store = '0;
        rif.cdb_val        = '0;
        rif.cdb_tag        = '0;
        rif.cdb_exc        = '0;
        flush              = 1'b0;
        cache_stall        = 1'b0;
    endtask

    task automatic set_alloc(input int n, input logic [DW-1:0] st);
        for (int i = 0; i < DW; i++) begin
            rif.alloc_val[i]          = (i < n);
            rif.alloc_rd[i*AW +: AW]  = AW'($urandom);
            rif.alloc_has_rd[i]       = 1'($urandom);
            rif.alloc_is_store[i]     = st[i];
        end
    endtask

    task automatic set_cdb(input int p, input int tag, input logic x);
        rif.cdb_val[p]           = 1'b1;
        rif.cdb_tag[p*TW +: TW]  = TW'(tag);
        rif.cdb_exc[p]           = x;
    endtask

    // Called at posedge+1 with inputs set: predict this cycle, advance one edge,
    // then apply the cycle's effects to the model.
    task automatic step();
        exp_t e;
        int   sz;
        int   nc;
        bit   seen;
        sz   = mq.size();
        nc   = 0;
        seen = 1'b0;
        e    = '0;
        e.rdy = (N - sz) >= DW;
        for (int i = 0; i < DW; i++) e.atag[i*TW +: TW] = TW'((mhead + sz + i) % N);
        if (!flush && !cache_stall) begin
            for (int j = 0; j < CW && j < sz; j++) begin
                if (!mq[j].done || mq[j].exc) break;
                if (mq[j].is_store && seen) break;
                e.cval[j]          = 1'b1;
                e.ctag[j*TW +: TW] = TW'(mq[j].tag);
                e.crd[j*AW +: AW]  = mq[j].rd;
                e.chas[j]          = mq[j].has_rd;
                if (mq[j].is_store) begin
                    seen   = 1'b1;
                    e.sval = 1'b1;
                    e.sid  = TW'(mq[j].tag);
                end
                nc++;
            end
        end
        if (sz > 0 && mq[0].done && mq[0].exc) begin
            e.xval = 1'b1;
            e.xtag = TW'(mq[0].tag);
        end
        e.head = TW'(mhead);
        e.tail = TW'((mhead + sz) % N);
        e.cnt  = (TW+1)'(sz);
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
            mhead = 0;
        end else begin
            for (int p = 0; p < CP; p++) begin
                if (rif.cdb_val[p]) begin
                    for (int j = 0; j < sz; j++) begin
                        if (mq[j].tag == int'(rif.cdb_tag[p*TW +: TW])) begin
                            mq[j].done = 1'b1;
                            mq[j].exc  = mq[j].exc | rif.cdb_exc[p];
                        end
                    end
                end
            end
            if (e.rdy) begin
                for (int i = 0; i < DW; i++) begin
                    if (rif.alloc_val[i]) begin
                        op_t o;
                        o.tag      = (mhead + sz + i) % N;
                        o.rd       = rif.alloc_rd[i*AW +: AW];
                        o.has_rd   = rif.alloc_has_rd[i];
                        o.is_store = rif.alloc_is_store[i];
                        o.done     = 1'b0;
                        o.exc      = 1'b0;
                        mq.push_back(o);
                    end
                end
            end
            for (int k = 0; k < nc; k++) void'(mq.pop_front());
            mhead = (mhead + nc) % N;
        end
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int exc_age;
        int t;
        idle();
        repeat (2) @(posedge clk);
        #1;
        // reset state while rst is held
        chk("rst_alloc_rdy",  64'(rif.alloc_rdy),  64'd1);
        chk("rst_alloc_tag",  64'(rif.alloc_tag),  64'h20);
        chk("rst_count",      64'(rob_count),      64'd0);
        chk("rst_commit_val", 64'(rif.commit_val), 64'd0);
        chk("rst_exc_val",    64'(rif.exc_val),    64'd0);
        rst = 1'b1;

        // fill to full, then one refused group
        for (int c = 0; c < 16; c++) begin
            idle(); set_alloc(2, 2'b00); step();
        end
        idle(); set_alloc(2, 2'b00); step();
        idle(); step();
        do_flush();

        // out-of-order completion 3,1,0,2
        for (int c = 0; c < 2; c++) begin
            idle(); set_alloc(2, 2'b00); step();
        end
        idle(); set_cdb(0, 3, 1'b0); step();
        idle(); set_cdb(0, 1, 1'b0); step();
        idle(); set_cdb(0, 0, 1'b0); step();
        idle(); set_cdb(0, 2, 1'b0); step();
        repeat (3) begin idle(); step(); end
        do_flush();

        // two done stores at head
        idle(); set_alloc(2, 2'b11); step();
        idle(); set_cdb(0, 0, 1'b0); set_cdb(1, 1, 1'b0); step();
        repeat (3) begin idle(); step(); end
        do_flush();

        // younger exception cuts the group, then holds at head until flush
        for (int c = 0; c < 3; c++) begin
            idle(); set_alloc(2, 2'b00); step();
        end
        idle(); set_cdb(0, 0, 1'b0); set_cdb(1, 1, 1'b0); step();
        idle(); set_cdb(0, 2, 1'b0); step();
        idle(); set_cdb(0, 3, 1'b0); set_cdb(1, 4, 1'b0); step();
        idle(); set_cdb(0, 5, 1'b1); step();
        repeat (5) begin idle(); step(); end
        do_flush();
        idle(); step();

        // cache_stall with done head while allocating
        idle(); set_alloc(2, 2'b00); step();
        idle(); set_cdb(0, 0, 1'b0); set_cdb(1, 1, 1'b0); step();
        idle(); cache_stall = 1'b1; set_alloc(2, 2'b00); step();
        idle(); cache_stall = 1'b1; set_alloc(1, 2'b00); step();
        repeat (3) begin idle(); step(); end
        do_flush();

        // random traffic across many wraps
        exc_age = 0;
        for (int c = 0; c < 1500; c++) begin
            idle();
            if (mq.size() > 0 && mq[0].done && mq[0].exc) exc_age++;
            else exc_age = 0;
            if (exc_age > 2 || $urandom_range(0, 199) == 0) flush = 1'b1;
            cache_stall = ($urandom_range(0, 7) == 0);
            set_alloc(int'($urandom_range(0, DW)), DW'($urandom));
            for (int p = 0; p < CP; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    if (mq.size() > 0 && $urandom_range(0, 9) != 0)
                        t = mq[$urandom_range(0, mq.size() - 1)].tag;
                    else
                        t = int'($urandom_range(0, N - 1));
                    set_cdb(p, t, ($urandom_range(0, 39) == 0));
                end
            end
            step();
        end

        // asynchronous reset mid-run
        idle();
        rst = 1'b0;
        #1;
        chk("midrst_count",      64'(rob_count),      64'd0);
        chk("midrst_head",       64'(rob_head),       64'd0);
        chk("midrst_alloc_rdy",  64'(rif.alloc_rdy),  64'd1);
        chk("midrst_commit_val", 64'(rif.commit_val), 64'd0);
        chk("midrst_exc_val",    64'(rif.exc_val),    64'd0);
        mq.delete();
        mhead = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            idle();
            set_alloc(int'($urandom_range(0, DW)), '0);
            if (mq.size() > 0) set_cdb(0, mq[0].tag, 1'b0);
            step();
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
